// File: rtl/red_pitaya_exp_in_pkg.sv
// Shared types and constants for the expansion-connector input conditioner.
package red_pitaya_exp_in_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;
  localparam int GLITCH_W    = 16;

  // Channel c < DWE is P bit c, otherwise N bit c-DWE.
  function automatic int ch_p(int b);
    return b;
  endfunction

  function automatic int ch_n(int dwe, int b);
    return dwe + b;
  endfunction

endpackage

// File: rtl/red_pitaya_exp_in_ch.sv
// One conditioned input bit: 2-flop synchroniser, debounce counter, stable level, edge pulses.
// EXP_IN_GLITCH_CNT_EN adds a saturating count of rejected pulses.
module red_pitaya_exp_in_ch
  import red_pitaya_exp_in_pkg::*;
#(
  parameter int CW = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pad_i,
  input  logic                load_i,
  input  logic                run_i,
  input  logic [CW-1:0]       deb_len_i,
`ifdef EXP_IN_GLITCH_CNT_EN
  input  logic                clr_i,
  output logic [GLITCH_W-1:0] glitch_cnt_o,
`endif
  output logic                dat_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                acc_rise_o,
  output logic                acc_fall_o
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s2;
  logic                   stable;
  logic [CW-1:0]          cnt;
  logic                   acc;

  assign s2         = sync[SYNC_STAGES-1];
  assign acc        = run_i && (s2 != stable) && (cnt >= deb_len_i);
  assign acc_rise_o = acc & s2;
  assign acc_fall_o = acc & ~s2;
  assign dat_o      = stable;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync   <= '0;
      stable <= 1'b0;
      cnt    <= '0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pad_i};
      rise_o <= acc_rise_o;
      fall_o <= acc_fall_o;
      if (load_i) begin
        stable <= s2;
        cnt    <= '0;
      end else if (run_i) begin
        if (s2 == stable) begin
          cnt <= '0;
        end else if (acc) begin
          stable <= s2;
          cnt    <= '0;
        end else if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef EXP_IN_GLITCH_CNT_EN
  // A rejected pulse is a level that returned to stable before acceptance.
  logic glitch;
  assign glitch = run_i && (s2 == stable) && (cnt != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i)                                  glitch_cnt_o <= '0;
    else if (clr_i)                             glitch_cnt_o <= '0;
    else if (glitch && (glitch_cnt_o != '1))    glitch_cnt_o <= glitch_cnt_o + 1'b1;
  end
`endif

endmodule

// File: rtl/red_pitaya_exp_in.sv
// Expansion-connector input conditioner: per-bit debounce, edge pulses, sticky events, irq.
// Optional EXP_IN_GLITCH_CNT_EN exposes per-channel rejected-pulse counters.
module red_pitaya_exp_in
  import red_pitaya_exp_in_pkg::*;
#(
  parameter int DWE = 8,
  parameter int CW  = 20
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DWE-1:0]               exp_p_pad_i,
  input  logic [DWE-1:0]               exp_n_pad_i,
  input  logic [CW-1:0]                deb_len_i,
  input  logic [2*DWE-1:0]             rise_msk_i,
  input  logic [2*DWE-1:0]             fall_msk_i,
  input  logic [2*DWE-1:0]             evt_clr_i,
  output logic [DWE-1:0]               exp_p_dat_o,
  output logic [DWE-1:0]               exp_n_dat_o,
  output logic [2*DWE-1:0]             rise_o,
  output logic [2*DWE-1:0]             fall_o,
  output logic [2*DWE-1:0]             evt_o,
  output logic                         irq_o,
`ifdef EXP_IN_GLITCH_CNT_EN
  output logic [2*DWE*GLITCH_W-1:0]    glitch_cnt_o,
`endif
  output logic                         ready_o
);

  state_t             state;
  logic               init_cnt;
  logic               load, run;
  logic [2*DWE-1:0]   pad, dat, acc_r, acc_f, evt_set;

  assign pad         = {exp_n_pad_i, exp_p_pad_i};
  assign load        = (state == ST_LOAD);
  assign run         = (state == ST_RUN);
  assign exp_p_dat_o = dat[DWE-1:0];
  assign exp_n_dat_o = dat[2*DWE-1:DWE];
  assign evt_set     = (acc_r & rise_msk_i) | (acc_f & fall_msk_i);

  for (genvar c = 0; c < 2*DWE; c++) begin : g_ch
    red_pitaya_exp_in_ch #(.CW(CW)) u_ch (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .pad_i        (pad[c]),
      .load_i       (load),
      .run_i        (run),
      .deb_len_i    (deb_len_i),
`ifdef EXP_IN_GLITCH_CNT_EN
      .clr_i        (evt_clr_i[c]),
      .glitch_cnt_o (glitch_cnt_o[c*GLITCH_W +: GLITCH_W]),
`endif
      .dat_o        (dat[c]),
      .rise_o       (rise_o[c]),
      .fall_o       (fall_o[c]),
      .acc_rise_o   (acc_r[c]),
      .acc_fall_o   (acc_f[c])
    );
  end

  // INIT spends two cycles letting the synchronisers fill before LOAD samples them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_INIT;
      init_cnt <= 1'b0;
      ready_o  <= 1'b0;
      evt_o    <= '0;
      irq_o    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= 1'b1;
          if (init_cnt) state <= ST_LOAD;
        end
        ST_LOAD: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
      ready_o <= run;
      evt_o   <= (evt_o & ~evt_clr_i) | evt_set;
      irq_o   <= |evt_o;
    end
  end

endmodule
